hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (I_FETCH → IDECODE → EXECUTE → MEMORY → writeback).
- Same-cycle outputs:
  - PC/IF-ID write enables.
  - ID/EX bubble insertion.
  - Per-stage flush on a taken branch resolved in MEMORY.
  - EX operand forwarding selects.
- Tracks stall state in a small FSM, with saturating stall/flush counters and a stall watchdog.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- FLUSH_DEPTH, 3, number of pipeline registers flushed on taken branch (bit 0 = IF/ID)
- CNT_W, 16, width of performance counters
- MAX_STALL, 4, consecutive stall cycles before watchdog fires

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads that source
- ex_rs, ex_rt  in  REG_ADDR_W  source specifiers in EX
- ex_rd  in  REG_ADDR_W  destination in EX (post regdst mux)
- ex_regwrite, ex_memread  in  1  EX control bits
- mem_rd  in  REG_ADDR_W  destination in MEM
- mem_regwrite  in  1  MEM control bit
- wb_rd  in  REG_ADDR_W  destination in WB
- wb_regwrite  in  1  WB control bit
- mem_pcsrc  in  1  taken branch resolved in MEM
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero ID/EX control fields
- flush  out  FLUSH_DEPTH  per-register flush
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters
- stall_err  out  1  sticky watchdog flag

## Operation
- Register 0 never creates a hazard and is never forwarded.
- Forwarding (FORWARDING_EN builds only):
  - fwd_a = 10 if mem_regwrite && mem_rd==ex_rs != 0.
  - Otherwise fwd_a = 01 if wb_regwrite && wb_rd==ex_rs != 0.
  - Otherwise fwd_a = 00.
  - EX/MEM has priority over MEM/WB.
  - fwd_b is identical, using ex_rt.
- Stall condition `haz`:
  - FORWARDING_EN: ex_memread && ex_regwrite && ex_rd matches a used ID source (load-use).
  - Without FORWARDING_EN: a used ID source matches ex_rd (ex_regwrite) or mem_rd (mem_regwrite).
  - WB writes first half-cycle, so WB never stalls.
- Stall effect: pc_write=0, if_id_write=0, id_ex_bubble=1.
- Taken branch: mem_pcsrc=1 → flush = all ones, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - A taken branch overrides a simultaneous stall.
  - The overridden stall is not counted.
- FSM states:
  - RUN → STALL on haz && !mem_pcsrc.
  - RUN/STALL → FLUSH on mem_pcsrc.
  - STALL stays while haz.
  - STALL → RUN on !haz.
  - FLUSH → RUN, or FLUSH → STALL per the same rules next cycle.
  - FLUSH always has priority.
- Run-length counter:
  - Increments each cycle in STALL with haz still true.
  - Clears on leaving STALL.
  - Reaching MAX_STALL sets stall_err, which stays set until rst.
- Counters:
  - stall_cnt increments on each cycle a stall is applied.
  - flush_cnt increments on each mem_pcsrc cycle.
  - Both saturate at all ones, with no wrap.

## Timing
- All control outputs are combinational from the current-cycle inputs (zero latency); stage registers sample them at the next clk edge.
- FSM, counters and stall_err are registered on posedge clk; updates are visible the cycle after the event.
- Reset values (asynchronous, effective immediately while rst=1):
  - State = RUN.
  - stall_cnt = flush_cnt = 0.
  - stall_err = 0.
  - pc_write = if_id_write = 0.
  - id_ex_bubble = 1.
  - flush = all ones.
  - fwd_a = fwd_b = 00.
- Reset mid-stall discards the run-length counter.
- Release of rst: outputs follow the normal rules in the first clk cycle.
- Without FORWARDING_EN, a dependent back-to-back pair stalls exactly 2 cycles; with it, a load-use pair stalls exactly 1.

## Configuration
- FORWARDING_EN defined:
  - Forwarding selects are active.
  - Only load-use stalls.
- FORWARDING_EN undefined:
  - fwd_a = fwd_b = 00 constant.
  - Stalls on any EX/MEM RAW dependency.

## Structure
- Shared package pipeline_pkg holds:
  - the FSM state encoding (RUN, STALL, FLUSH);
  - the fwd select constants FWD_RF, FWD_EXMEM, FWD_MEMWB;
  - the default REG_ADDR_W.
- One sub-module, fwd_unit: pure combinational forwarding selection, instantiated only under FORWARDING_EN.

## Test plan
- lw $2 in EX (ex_memread=1, ex_rd=2), ID add reads $2:
  - Build with FORWARDING_EN → one cycle pc_write=0, id_ex_bubble=1; stall_cnt=1.
  - Next cycle fwd_a=01.
- add $3 in MEM (mem_rd=3), EX reads $3 as rs, WB also writes $3 → fwd_a=10 (EX/MEM priority).
- Build without FORWARDING_EN, ID reads $4, EX writes $4 → stall exactly 2 cycles; fwd_a/fwd_b stay 00.
- mem_pcsrc=1 coincident with load-use:
  - flush=3'b111, pc_write=1, id_ex_bubble=0.
  - flush_cnt +1, stall_cnt unchanged.
- Writes to $0 in EX/MEM/WB against ID/EX reads of $0 → no stall, fwd=00.
- Hold haz for MAX_STALL=4 cycles → stall_err=1.
  - stall_err remains after haz drops.
  - Async rst mid-stall clears all counters, stall_err and state without a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, forwarding selects, default specifier width.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StFlush
  } hazard_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(logic hit_exmem, logic hit_memwb);
    if (hit_exmem) begin
      return FWD_EXMEM;
    end else if (hit_memwb) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle; the pipeline is the master, hazard_ctrl the slave.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W  = pipeline_pkg::REG_ADDR_W_DEF,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_W       = 16
);
  logic [REG_ADDR_W-1:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic                   id_uses_rs, id_uses_rt;
  logic                   ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mem_pcsrc;
  logic                   pc_write, if_id_write, id_ex_bubble;
  logic [FLUSH_DEPTH-1:0] flush;
  logic [1:0]             fwd_a, fwd_b;
  logic [CNT_W-1:0]       stall_cnt, flush_cnt;
  logic                   stall_err;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_pcsrc,
    input  pc_write, if_id_write, id_ex_bubble, flush, fwd_a, fwd_b,
    input  stall_cnt, flush_cnt, stall_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_pcsrc,
    output pc_write, if_id_write, id_ex_bubble, flush, fwd_a, fwd_b,
    output stall_cnt, flush_cnt, stall_err
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational EX operand forwarding selection; register 0 is never forwarded.
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
);
  logic mem_live, wb_live;

  assign mem_live = mem_regwrite_i && (mem_rd_i != '0);
  assign wb_live  = wb_regwrite_i && (wb_rd_i != '0);

  assign fwd_a_o = fwd_sel(mem_live && (mem_rd_i == ex_rs_i), wb_live && (wb_rd_i == ex_rs_i));
  assign fwd_b_o = fwd_sel(mem_live && (mem_rd_i == ex_rt_i), wb_live && (wb_rd_i == ex_rt_i));
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, branch flush and forwarding control with stall watchdog.
// Define FORWARDING_EN to enable EX forwarding (then only load-use hazards stall).
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_STALL   = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned RunW = $clog2(MAX_STALL + 1);

  hazard_state_e    state_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [RunW-1:0]  run_q, run_d;
  logic             err_q;
  logic             rs_live, rt_live, haz, stall_apply;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign rs_live = bus.id_uses_rs && (bus.id_rs != '0);
  assign rt_live = bus.id_uses_rt && (bus.id_rt != '0);

`ifdef FORWARDING_EN
  assign haz = bus.ex_memread && bus.ex_regwrite &&
               ((rs_live && (bus.id_rs == bus.ex_rd)) || (rt_live && (bus.id_rt == bus.ex_rd)));

  fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_unit (
    .ex_rs_i       (bus.ex_rs),
    .ex_rt_i       (bus.ex_rt),
    .mem_rd_i      (bus.mem_rd),
    .mem_regwrite_i(bus.mem_regwrite),
    .wb_rd_i       (bus.wb_rd),
    .wb_regwrite_i (bus.wb_regwrite),
    .fwd_a_o       (fwd_a_raw),
    .fwd_b_o       (fwd_b_raw)
  );
`else
  logic unused_fwd_inputs;

  // WB writes the regfile in the first half-cycle, so only EX and MEM writers matter.
  assign haz = (rs_live && ((bus.ex_regwrite && (bus.id_rs == bus.ex_rd)) ||
                            (bus.mem_regwrite && (bus.id_rs == bus.mem_rd)))) ||
               (rt_live && ((bus.ex_regwrite && (bus.id_rt == bus.ex_rd)) ||
                            (bus.mem_regwrite && (bus.id_rt == bus.mem_rd))));
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
  assign unused_fwd_inputs = ^{bus.ex_rs, bus.ex_rt, bus.wb_rd, bus.wb_regwrite, bus.ex_memread};
`endif

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.id_ex_bubble = 1'b0;
    bus.flush        = '0;
    bus.fwd_a        = fwd_a_raw;
    bus.fwd_b        = fwd_b_raw;
    stall_apply      = 1'b0;
    if (rst) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
      bus.flush        = '1;
      bus.fwd_a        = FWD_RF;
      bus.fwd_b        = FWD_RF;
    end else if (bus.mem_pcsrc) begin
      bus.flush = '1;
    end else if (haz) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
      stall_apply      = 1'b1;
    end
  end

  // Run length counts consecutive applied stall cycles, including the one entering STALL.
  always_comb begin
    run_d = '0;
    if (stall_apply) begin
      if (state_q != StStall) begin
        run_d = RunW'(1);
      end else if (run_q != RunW'(MAX_STALL)) begin
        run_d = run_q + RunW'(1);
      end else begin
        run_d = run_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (bus.mem_pcsrc) begin
        state_q <= StFlush;
      end else if (haz) begin
        state_q <= StStall;
      end else begin
        state_q <= StRun;
      end
      if (stall_apply && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.mem_pcsrc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      run_q <= run_d;
      if (run_d >= RunW'(MAX_STALL)) err_q <= 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.stall_err = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl against a per-cycle behavioural model, plus directed cases.
module tb_hazard_ctrl;
  localparam int unsigned RW  = 5;
  localparam int unsigned FD  = 3;
  localparam int unsigned CW  = 6;
  localparam int unsigned MXS = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
  localparam int unsigned FL_ONES = (1 << FD) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(RW), .FLUSH_DEPTH(FD), .CNT_W(CW)) bus ();

  hazard_ctrl #(
    .REG_ADDR_W (RW),
    .FLUSH_DEPTH(FD),
    .CNT_W      (CW),
    .MAX_STALL  (MXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  int m_stall_cnt, m_flush_cnt, m_run;
  bit m_err;

  function automatic bit reads(logic [RW-1:0] src, bit used, logic [RW-1:0] dst, bit we);
    return used && we && (src != 0) && (src == dst);
  endfunction

  function automatic bit m_haz();
    logic [RW-1:0] srcs [2];
    bit            used [2];
    bit            h = 0;
    srcs[0] = bus.id_rs; used[0] = bus.id_uses_rs;
    srcs[1] = bus.id_rt; used[1] = bus.id_uses_rt;
    for (int i = 0; i < 2; i++) begin
`ifdef FORWARDING_EN
      if (bus.ex_memread && reads(srcs[i], used[i], bus.ex_rd, bus.ex_regwrite)) h = 1;
`else
      if (reads(srcs[i], used[i], bus.ex_rd, bus.ex_regwrite)) h = 1;
      if (reads(srcs[i], used[i], bus.mem_rd, bus.mem_regwrite)) h = 1;
`endif
    end
    return h;
  endfunction

  function automatic logic [1:0] m_fwd(logic [RW-1:0] src);
    if (rst) return 2'b00;
`ifdef FORWARDING_EN
    if (reads(src, 1'b1, bus.mem_rd, bus.mem_regwrite)) return 2'b10;
    if (reads(src, 1'b1, bus.wb_rd, bus.wb_regwrite)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit m_stalling();
    return !rst && !bus.mem_pcsrc && m_haz();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      m_run       = 0;
      m_err       = 0;
    end else begin
      if (m_stalling()) begin
        if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
        m_run++;
        if (m_run >= MXS) m_err = 1;
      end else begin
        m_run = 0;
      end
      if (bus.mem_pcsrc && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    end
  end

  // Every cycle: compare all DUT outputs with the model away from the clock edge.
  always @(negedge clk) begin
    bit st;
    st = m_stalling();
    check("pc_write", bus.pc_write, (rst || st) ? 0 : 1);
    check("if_id_write", bus.if_id_write, (rst || st) ? 0 : 1);
    check("id_ex_bubble", bus.id_ex_bubble, (rst || st) ? 1 : 0);
    check("flush", bus.flush, (rst || bus.mem_pcsrc) ? FL_ONES : 0);
    check("fwd_a", bus.fwd_a, m_fwd(bus.ex_rs));
    check("fwd_b", bus.fwd_b, m_fwd(bus.ex_rt));
    check("stall_cnt", bus.stall_cnt, m_stall_cnt);
    check("flush_cnt", bus.flush_cnt, m_flush_cnt);
    check("stall_err", bus.stall_err, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_memread = 0;
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.wb_rd = 0; bus.wb_regwrite = 0;
    bus.mem_pcsrc = 0;
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_load_use(logic [RW-1:0] r);
    idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = r;
    bus.id_rt = r; bus.id_uses_rt = 1;
  endtask

  initial begin
    idle();
    #1 rst = 1;
    #2;
    check("rst pc_write", bus.pc_write, 0);
    check("rst if_id_write", bus.if_id_write, 0);
    check("rst bubble", bus.id_ex_bubble, 1);
    check("rst flush", bus.flush, 3'b111);
    check("rst fwd_a", bus.fwd_a, 0);
    check("rst stall_cnt", bus.stall_cnt, 0);
    check("rst stall_err", bus.stall_err, 0);
    cyc(1);
    rst = 0;

    // Writes to $0 everywhere against reads of $0.
    bus.ex_rd = 0; bus.ex_regwrite = 1; bus.ex_memread = 1;
    bus.mem_rd = 0; bus.mem_regwrite = 1; bus.wb_rd = 0; bus.wb_regwrite = 1;
    bus.id_uses_rs = 1; bus.id_uses_rt = 1;
    #1;
    check("r0 pc_write", bus.pc_write, 1);
    check("r0 bubble", bus.id_ex_bubble, 0);
    check("r0 fwd_a", bus.fwd_a, 0);
    check("r0 fwd_b", bus.fwd_b, 0);
    cyc(1);

    // Taken branch coincident with a load-use hazard.
    set_load_use(2);
    bus.mem_pcsrc = 1;
    #1;
    check("br flush", bus.flush, 3'b111);
    check("br pc_write", bus.pc_write, 1);
    check("br bubble", bus.id_ex_bubble, 0);
    cyc(1);
    check("br flush_cnt", bus.flush_cnt, 1);
    check("br stall_cnt", bus.stall_cnt, 0);

`ifdef FORWARDING_EN
    // lw $2 in EX, add reads $2 in ID.
    set_load_use(2);
    bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_rs = 2; bus.id_uses_rs = 1;
    #1;
    check("lu pc_write", bus.pc_write, 0);
    check("lu bubble", bus.id_ex_bubble, 1);
    cyc(1);
    check("lu stall_cnt", bus.stall_cnt, 1);
    bus.ex_memread = 0; bus.ex_regwrite = 0; bus.mem_rd = 2; bus.mem_regwrite = 1;
    #1;
    check("lu release", bus.pc_write, 1);
    cyc(1);
    idle();
    bus.ex_rs = 2; bus.wb_rd = 2; bus.wb_regwrite = 1;
    #1;
    check("lu fwd_a", bus.fwd_a, 2'b01);
    cyc(1);
    // EX/MEM has priority over MEM/WB.
    idle();
    bus.ex_rs = 3; bus.ex_rt = 3; bus.mem_rd = 3; bus.mem_regwrite = 1;
    bus.wb_rd = 3; bus.wb_regwrite = 1;
    #1;
    check("prio fwd_a", bus.fwd_a, 2'b10);
    check("prio fwd_b", bus.fwd_b, 2'b10);
    cyc(1);
    check("fw stall_cnt", bus.stall_cnt, 1);
`else
    // Dependent pair on $4 walks EX then MEM: two stall cycles.
    idle();
    bus.id_rs = 4; bus.id_uses_rs = 1; bus.ex_rd = 4; bus.ex_regwrite = 1; bus.ex_rs = 4;
    #1;
    check("dep1 pc_write", bus.pc_write, 0);
    check("dep1 bubble", bus.id_ex_bubble, 1);
    cyc(1);
    bus.ex_regwrite = 0; bus.mem_rd = 4; bus.mem_regwrite = 1;
    #1;
    check("dep2 pc_write", bus.pc_write, 0);
    check("dep2 fwd_a", bus.fwd_a, 0);
    cyc(1);
    bus.mem_regwrite = 0; bus.wb_rd = 4; bus.wb_regwrite = 1;
    #1;
    check("dep3 pc_write", bus.pc_write, 1);
    check("dep3 fwd_a", bus.fwd_a, 0);
    cyc(1);
    check("dep stall_cnt", bus.stall_cnt, 2);
`endif

    // Watchdog: MAX_STALL consecutive stall cycles.
    set_load_use(5);
    cyc(MXS - 1);
    check("wd early", bus.stall_err, 0);
    cyc(1);
    check("wd fire", bus.stall_err, 1);
    idle();
    cyc(2);
    check("wd sticky", bus.stall_err, 1);

    // Randomised traffic with small register range to provoke hits.
    for (int i = 0; i < 600; i++) begin
      bus.id_rs = RW'($urandom_range(0, 3)); bus.id_rt = RW'($urandom_range(0, 3));
      bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
      bus.ex_rs = RW'($urandom_range(0, 3)); bus.ex_rt = RW'($urandom_range(0, 3));
      bus.ex_rd = RW'($urandom_range(0, 3));
      bus.ex_regwrite = 1'($urandom); bus.ex_memread = 1'($urandom);
      bus.mem_rd = RW'($urandom_range(0, 3)); bus.mem_regwrite = 1'($urandom);
      bus.wb_rd = RW'($urandom_range(0, 3)); bus.wb_regwrite = 1'($urandom);
      bus.mem_pcsrc = ($urandom_range(0, 7) == 0);
      cyc(1);
    end
    check("sat flush_cnt", bus.flush_cnt, CNT_MAX);

    // Asynchronous reset mid-stall, then the run length must restart from zero.
    set_load_use(6);
    cyc(2);
    #2 rst = 1;
    #1;
    check("arst stall_cnt", bus.stall_cnt, 0);
    check("arst flush_cnt", bus.flush_cnt, 0);
    check("arst stall_err", bus.stall_err, 0);
    check("arst pc_write", bus.pc_write, 0);
    cyc(1);
    rst = 0;
    cyc(MXS - 1);
    check("arst no wd", bus.stall_err, 0);
    check("arst stall_cnt2", bus.stall_cnt, MXS - 1);
    idle();
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
